product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter N, default 6: width of each incoming product.
REQ-002 Parameter ACC_W, default 8: accumulator and result width; ACC_W SHALL be >= N.
REQ-003 Parameter CNT_W, default 4: batch-length field width; maximum batch is 2^CNT_W beats.
REQ-004 Port clk  input  1: single clock; all state changes on the rising edge.
REQ-005 Port rst_n  input  1: asynchronous, active-low reset.
REQ-006 Port recv_val  input  1: upstream product valid.
REQ-007 Port recv_rdy  output  1: block can accept a product this cycle.
REQ-008 Port recv_msg  input  N: unsigned product from the upstream multiplier.
REQ-009 Port len  input  CNT_W: products per batch; 0 encodes 2^CNT_W; sampled only on the first beat of a batch.
REQ-010 Port send_val  output  1: batch sum valid.
REQ-011 Port send_rdy  input  1: downstream ready.
REQ-012 Port send_msg  output  ACC_W: saturated batch sum.
REQ-013 Port send_sat  output  1: saturation occurred during this batch.

Function
REQ-014 Handshakes SHALL use val/rdy: a transfer occurs only on a rising edge where val and rdy are both 1; rdy SHALL NOT depend combinationally on val.
REQ-015 The FSM SHALL have three states: IDLE (no batch open), ACCUM (batch open), DONE (result held).
REQ-016 recv_rdy SHALL be 1 in IDLE and ACCUM and 0 in DONE; send_val SHALL be 1 only in DONE.
REQ-017 IDLE transfer: acc <= zero-extended recv_msg; sat <= 0; remaining <= effective length - 1.
REQ-018 IDLE transfer with effective length 1: next state DONE; otherwise next state ACCUM.
REQ-019 ACCUM transfer: acc <= min(acc + recv_msg, 2^ACC_W - 1); sat set if the unclamped sum exceeds 2^ACC_W - 1; remaining decrements by 1.
REQ-020 Once sat is set, it SHALL remain set until the batch result is consumed.
REQ-021 ACCUM transfer with remaining == 1: next state DONE; the final beat SHALL be included in the sum.
REQ-022 ACCUM with recv_val = 0: acc, sat and remaining hold.
REQ-023 Latency: send_val SHALL assert on the cycle after the last product transfer.
REQ-024 In DONE, send_msg = acc and send_sat = sat; both SHALL stay stable while send_val = 1 and send_rdy = 0.
REQ-025 DONE transfer: next state IDLE; acc and sat clear. recv_rdy returns to 1 the following cycle.
REQ-026 The send transfer and the next batch's first beat SHALL NOT coincide; at least one cycle separates them.
REQ-027 Changes on len while in ACCUM or DONE SHALL have no effect.
REQ-028 send_msg SHALL read 0 and send_sat 0 whenever the state is not DONE.
REQ-029 The internal sum SHALL be at least ACC_W+1 bits wide so saturation detection never wraps.

Reset
REQ-030 While rst_n = 0, the state SHALL be IDLE and acc, sat and remaining SHALL be 0.
REQ-031 While rst_n = 0, recv_rdy, send_val, send_msg and send_sat SHALL all be 0, independent of clk.
REQ-032 Reset asserted mid-batch or in DONE SHALL discard the partial result; no send transfer follows.
REQ-033 After rst_n rises, recv_rdy SHALL be 1 at the first clock edge.

Verification
REQ-034 len = 3; products 5, 10, 20 with no gaps -> send_val on the cycle after the 20 transfer, send_msg = 35, send_sat = 0.
REQ-035 len = 5; five products of 63 -> send_msg = 255, send_sat = 1; recv_rdy = 0 while DONE.
REQ-036 len = 0; sixteen products of 1, with len changed to 2 after the first beat -> send_msg = 16, send_sat = 0.
REQ-037 len = 2; products 7 and 9 with recv_val dropped 3 cycles between them, then send_rdy held low 4 cycles -> send_msg = 16, held stable throughout, and released after the send_rdy handshake; IDLE one cycle later.
REQ-038 len = 4; two products accepted, then rst_n pulsed low mid-cycle -> all outputs 0 immediately; a new len = 1 batch of 42 yields send_msg = 42.
REQ-039 len = 1; product 63; send_rdy tied 1 -> send_val pulses for exactly one cycle with send_msg = 63; back-to-back batches alternate recv_rdy 1/0 as required.

Source files
------------

// File: rtl/product_accumulator.sv
// Batch accumulator: sums a run of unsigned products into a saturating
// accumulator and presents the total (plus a sticky saturation flag) downstream.
// Upstream and downstream both use a val/rdy handshake.
module product_accumulator #(
    parameter int N     = 6,   // product width
    parameter int ACC_W = 8,   // accumulator/result width, must be >= N
    parameter int CNT_W = 4    // batch-length width; len == 0 means 2^CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             recv_val,
    output logic             recv_rdy,
    input  logic [N-1:0]     recv_msg,
    input  logic [CNT_W-1:0] len,
    output logic             send_val,
    input  logic             send_rdy,
    output logic [ACC_W-1:0] send_msg,
    output logic             send_sat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Largest representable result, one bit wider so it compares against the sum.
    localparam logic [ACC_W:0] ACC_MAX = {1'b0, {ACC_W{1'b1}}};

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic             sat_q;
    logic [CNT_W-1:0] rem_q;   // beats still expected after the current one

    logic [ACC_W:0]   sum_d;   // one guard bit so overflow is never lost
    logic [CNT_W-1:0] rem_d;   // len - 1; wraps so len == 0 gives 2^CNT_W - 1

    // Unclamped running sum and the remaining-beat count for a new batch.
    always_comb begin
        sum_d = {1'b0, acc_q} + (ACC_W+1)'(recv_msg);
        rem_d = len - CNT_W'(1);
    end

    // Handshake outputs derive from state only; rst_n gating keeps them low
    // during reset without waiting for a clock.
    assign recv_rdy = rst_n && (state_q != DONE);
    assign send_val = rst_n && (state_q == DONE);
    assign send_msg = send_val ? acc_q : '0;
    assign send_sat = send_val ? sat_q : 1'b0;

    // Batch FSM: open on the first beat, accumulate with clamp, hold result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (recv_val) begin
                        acc_q   <= ACC_W'(recv_msg);
                        sat_q   <= 1'b0;
                        rem_q   <= rem_d;
                        state_q <= (len == CNT_W'(1)) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (recv_val) begin
                        if (sum_d > ACC_MAX) begin
                            acc_q <= ACC_MAX[ACC_W-1:0];
                            sat_q <= 1'b1;
                        end else begin
                            acc_q <= sum_d[ACC_W-1:0];
                        end
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) state_q <= DONE;
                    end
                end
                DONE: begin
                    if (send_rdy) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                        sat_q   <= 1'b0;
                        rem_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed batches plus random traffic, all
// checked every cycle against a batch-level reference model.
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       recv_val;
    logic       recv_rdy;
    logic [5:0] recv_msg;
    logic [3:0] len;
    logic       send_val;
    logic       send_rdy;
    logic [7:0] send_msg;
    logic       send_sat;

    int total = 0;
    int bad   = 0;

    // Reference model: batch state in plain integers.
    bit m_open;    // batch in progress
    bit m_done;    // result waiting for downstream
    int m_left;    // beats still to come in the open batch
    int m_total;   // exact (unclamped) sum of the batch

    product_accumulator #(.N(6), .ACC_W(8), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .recv_msg (recv_msg),
        .len      (len),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .send_msg (send_msg),
        .send_sat (send_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_msg();
        if (!m_done) return 0;
        return (m_total > 255) ? 255 : m_total;
    endfunction

    function automatic int exp_sat();
        return (m_done && m_total > 255) ? 1 : 0;
    endfunction

    task automatic model_clear();
        m_open = 0; m_done = 0; m_left = 0; m_total = 0;
    endtask

    // One cycle: check outputs at the falling edge, then drive the inputs the
    // next rising edge will see and advance the model accordingly.
    task automatic step(input bit v, input int m, input int l, input bit sr);
        @(negedge clk);
        chk("recv_rdy", recv_rdy, m_done ? 0 : 1);
        chk("send_val", send_val, m_done ? 1 : 0);
        chk("send_msg", send_msg, exp_msg());
        chk("send_sat", send_sat, exp_sat());
        recv_val = v;
        recv_msg = 6'(m);
        len      = 4'(l);
        send_rdy = sr;
        if (m_done) begin
            if (sr) begin
                m_done  = 0;
                m_total = 0;
            end
        end else if (v) begin
            if (!m_open) begin
                m_open  = 1;
                m_left  = (l == 0) ? 16 : l;
                m_total = 0;
            end
            m_total += m;
            m_left--;
            if (m_left == 0) begin
                m_open = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic idle(input int n, input bit sr);
        for (int i = 0; i < n; i++) step(0, 0, 0, sr);
    endtask

    // Asynchronous reset pulse away from any clock edge.
    task automatic pulse_reset();
        #3 rst_n = 1'b0;
        recv_val = 1'b0;
        send_rdy = 1'b0;
        #1;
        chk("rst_recv_rdy", recv_rdy, 0);
        chk("rst_send_val", send_val, 0);
        chk("rst_send_msg", send_msg, 0);
        chk("rst_send_sat", send_sat, 0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_val", send_val, 0);
        rst_n = 1'b1;
        #1 chk("rst_rel_rdy", recv_rdy, 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        recv_val = 1'b0;
        recv_msg = '0;
        len      = '0;
        send_rdy = 1'b0;
        model_clear();
        #3;
        chk("init_recv_rdy", recv_rdy, 0);
        chk("init_send_val", send_val, 0);
        chk("init_send_msg", send_msg, 0);
        chk("init_send_sat", send_sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("init_rel_rdy", recv_rdy, 1);

        // len 3: 5 + 10 + 20
        step(1, 5, 3, 0); step(1, 10, 3, 0); step(1, 20, 3, 0);
        step(0, 0, 0, 0);
        chk("b34_val", send_val, 1);
        chk("b34_msg", send_msg, 35);
        chk("b34_sat", send_sat, 0);
        step(0, 0, 0, 1);
        idle(1, 0);

        // len 5: five 63s saturate
        for (int i = 0; i < 5; i++) step(1, 63, 5, 0);
        step(1, 1, 5, 0);   // offered while DONE, must be refused
        chk("b35_msg", send_msg, 255);
        chk("b35_sat", send_sat, 1);
        chk("b35_rdy", recv_rdy, 0);
        step(0, 0, 0, 1);
        idle(1, 0);

        // len 0 = 16 beats; len changed after first beat must be ignored
        step(1, 1, 0, 0);
        for (int i = 0; i < 15; i++) step(1, 1, 2, 0);
        step(0, 0, 2, 0);
        chk("b36_msg", send_msg, 16);
        chk("b36_sat", send_sat, 0);
        step(0, 0, 0, 1);
        idle(1, 0);

        // len 2 with gaps, then downstream stall
        step(1, 7, 2, 0);
        idle(3, 0);
        step(1, 9, 2, 0);
        idle(4, 0);
        chk("b37_msg", send_msg, 16);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("b37_idle_rdy", recv_rdy, 1);
        chk("b37_idle_val", send_val, 0);

        // reset mid-batch, then a fresh single-beat batch
        step(1, 30, 4, 0); step(1, 30, 4, 0);
        pulse_reset();
        step(1, 42, 1, 0);
        step(0, 0, 0, 0);
        chk("b38_msg", send_msg, 42);
        step(0, 0, 0, 1);
        idle(1, 0);

        // reset while a result is held: it must be discarded
        step(1, 11, 1, 0);
        step(0, 0, 0, 0);
        pulse_reset();
        idle(2, 1);

        // len 1 back-to-back with send_rdy tied high
        for (int i = 0; i < 6; i++) step(1, 63, 1, 1);
        idle(2, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int l;
            l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 5));
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 63)), l, ($urandom_range(0, 2) != 0));
        end
        idle(40, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
